demux_load_sequencer: RTL and testbench
=======================================

# demux_load_sequencer

Controller that sequences the digit demultiplexer: on a start pulse it fetches NUM_FIELDS 4-bit digits, one at a time, from a source over a req/ack read handshake. It writes each digit into the demux by presenting the digit on `dmx_data_o` and its slot index on `dmx_sel_o` for exactly one cycle. Between writes it parks the select on an out-of-range code, so the demux holds every output register. It sits between the time/date source logic and the demux that feeds the display/register slots.

## Interface
- `NUM_FIELDS`, 9: number of demux slots loaded per sequence (1..15).
- `ACK_TIMEOUT`, 15: maximum cycles to wait for `rd_ack_i` per field (1..255).
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `busy_o` out 1: high from the cycle after start is accepted until DONE ends.
- `done_o` out 1: one-cycle pulse at sequence end (normal or aborted).
- `timeout_o` out 1: sticky; set on ack timeout, cleared on next accepted start.
- `rd_req_o` out 1: read request to digit source.
- `rd_addr_o` out 4: field index being requested.
- `rd_ack_i` in 1: source acknowledge; `rd_data_i` valid in the same cycle.
- `rd_data_i` in 4: digit from source.
- `dmx_sel_o` out 4: demux select; 4'hF when parked.
- `dmx_data_o` out 4: demux data.
- `bcd_err_o` out 1: sticky BCD error (only with macro, else tied 0).

## Operation
- States: IDLE, REQ, WRITE, DONE.
- IDLE: `dmx_sel_o`=4'hF. `start_i`=1 -> REQ, field index=0, timeout counter=0, clear `timeout_o`/`bcd_err_o`.
- REQ: `rd_req_o`=1, `rd_addr_o`=index. On `rd_ack_i`=1: capture `rd_data_i` into `dmx_data_o`, `dmx_sel_o`=index -> WRITE. Otherwise the counter increments. When the counter reaches ACK_TIMEOUT-1 without ack: set `timeout_o` -> DONE. Remaining slots are not written.
- WRITE: `dmx_sel_o`/`dmx_data_o` are held for this one cycle and the demux captures at the end of it. If index==NUM_FIELDS-1 -> DONE; else index+1, counter=0 -> REQ.
- DONE: `done_o`=1, `dmx_sel_o`=4'hF, `rd_req_o`=0 -> IDLE.
- `start_i` outside IDLE is ignored. `rd_ack_i` outside REQ is ignored.
- `dmx_sel_o` is 4'hF in every state except WRITE, so the demux never writes an unintended slot.
- Index is 4 bits; no wrap; the sequence ends at NUM_FIELDS-1.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `timeout_o`=0, `bcd_err_o`=0, `rd_req_o`=0, `rd_addr_o`=0, `dmx_sel_o`=4'hF, `dmx_data_o`=0; state=IDLE.
- Start accepted at edge N. `rd_req_o` is high from N+1.
- Ack in the first REQ cycle gives 2 cycles per field. Total: start edge to `done_o` high = 2*NUM_FIELDS+1 cycles (19 for default).
- An ack arriving k cycles late adds k cycles for that field.
- `rd_req_o` drops in the cycle after ack (WRITE).
- Reset mid-sequence: immediate return to reset values. The sel park means demux contents already written stay; unwritten slots keep their old values.

## Configuration
- `DEMUX_LOAD_BCD_CHECK_EN` defined: a captured digit > 9 is replaced by 0 on `dmx_data_o`, `bcd_err_o` is set (sticky until the next start), and the sequence continues.
- Not defined: digits pass unmodified and `bcd_err_o` is tied 0.

## Structure
- Shared package: state encoding enum (IDLE/REQ/WRITE/DONE), SEL_PARK=4'hF, DIGIT_W=4, BCD_MAX=9.
- Optional sub-module `ack_timeout_counter` (clear/enable/expired) for the per-field wait counter; the FSM stays in one module.

## Test plan
- Start with an immediate-ack source returning 1..9: slots 0..8 are written with 1..9, `done_o` arrives at start+19, and `dmx_sel_o`=4'hF outside WRITE.
- Ack delayed 3 cycles on field 4: only that field stretches by 3, giving `done_o` at start+22, and all data is correct.
- No ack on field 2 with ACK_TIMEOUT=15: `timeout_o`=1 after 15 REQ cycles, `done_o` pulses, slots 2..8 are unchanged, and the next start clears `timeout_o`.
- Reset asserted mid-field 5: outputs reach reset values immediately, slots 0..4 hold their values, and `start_i` then gives a normal full sequence.
- `start_i` pulsed during busy, plus `rd_ack_i` pulsed in IDLE: both are ignored, with no extra write and no restart.
- With `DEMUX_LOAD_BCD_CHECK_EN`, the source returns 4'hC on field 3: slot 3 is written with 0, `bcd_err_o`=1, and the sequence completes.

Source files
------------

// File: rtl/demux_load_sequencer_pkg.sv
// Shared types and constants for the demux load sequencer.
package demux_load_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned BCD_MAX  = 9;
    localparam logic [3:0]  SEL_PARK = 4'hF;

endpackage

// File: rtl/demux_load_sequencer_ack_timeout_counter.sv
// Per-field acknowledge wait counter; expired once LIMIT wait cycles have elapsed.
module ack_timeout_counter #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == 8'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_load_sequencer.sv
// Fetches NUM_FIELDS digits over req/ack and writes each into the demux for one cycle.
// Optional BCD range check enabled by defining DEMUX_LOAD_BCD_CHECK_EN.
module demux_load_sequencer
    import demux_load_sequencer_pkg::*;
#(
    parameter int unsigned NUM_FIELDS  = 9,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic               rd_req_o,
    output logic [3:0]         rd_addr_o,
    input  logic               rd_ack_i,
    input  logic [DIGIT_W-1:0] rd_data_i,
    output logic [3:0]         dmx_sel_o,
    output logic [DIGIT_W-1:0] dmx_data_o,
    output logic               bcd_err_o
);

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [DIGIT_W-1:0] data_q, data_d;
    logic               timeout_q, timeout_d;
    logic               bcd_q, bcd_d;
    logic               expired;

    ack_timeout_counter #(
        .LIMIT (ACK_TIMEOUT)
    ) u_ack_timeout_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != ST_REQ),
        .enable_i  ((state_q == ST_REQ) && !rd_ack_i),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        timeout_d = timeout_q;
        bcd_d     = bcd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_REQ;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                    bcd_d     = 1'b0;
                end
            end
            ST_REQ: begin
                // Ack wins over expiry when both land in the final wait cycle.
                if (rd_ack_i) begin
                    data_d  = rd_data_i;
`ifdef DEMUX_LOAD_BCD_CHECK_EN
                    if (rd_data_i > DIGIT_W'(BCD_MAX)) begin
                        data_d = '0;
                        bcd_d  = 1'b1;
                    end
`endif
                    state_d = ST_WRITE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (idx_q == 4'(NUM_FIELDS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
            bcd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign rd_req_o   = (state_q == ST_REQ);
    assign rd_addr_o  = idx_q;
    assign dmx_sel_o  = (state_q == ST_WRITE) ? idx_q : SEL_PARK;
    assign dmx_data_o = data_q;
    assign timeout_o  = timeout_q;
`ifdef DEMUX_LOAD_BCD_CHECK_EN
    assign bcd_err_o  = bcd_q;
`else
    assign bcd_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_demux_load_sequencer.sv
// Randomized self-checking bench: a source/demux model around the sequencer and a per-sequence reference.
module tb_demux_load_sequencer;

    localparam int NF = 9;
    localparam int TO = 15;
    localparam int NEVER = 1000;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       busy_o, done_o, timeout_o, rd_req_o, rd_ack_i, bcd_err_o;
    logic [3:0] rd_addr_o, rd_data_i, dmx_sel_o, dmx_data_o;

    int n_checks = 0;
    int n_errors = 0;

    int         dly [NF];
    logic [3:0] dat [NF];
    logic [3:0] slots [16];

    demux_load_sequencer #(
        .NUM_FIELDS  (NF),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .rd_req_o   (rd_req_o),
        .rd_addr_o  (rd_addr_o),
        .rd_ack_i   (rd_ack_i),
        .rd_data_i  (rd_data_i),
        .dmx_sel_o  (dmx_sel_o),
        .dmx_data_o (dmx_data_o),
        .bcd_err_o  (bcd_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] filt(input logic [3:0] d);
`ifdef DEMUX_LOAD_BCD_CHECK_EN
        return (d > 4'd9) ? 4'd0 : d;
`else
        return d;
`endif
    endfunction

    function automatic bit bad_digit(input logic [3:0] d);
`ifdef DEMUX_LOAD_BCD_CHECK_EN
        return d > 4'd9;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_tmo"}, timeout_o, 0);
        check({tag, "_bcd"}, bcd_err_o, 0);
        check({tag, "_req"}, rd_req_o, 0);
        check({tag, "_addr"}, rd_addr_o, 0);
        check({tag, "_sel"}, dmx_sel_o, 15);
        check({tag, "_data"}, dmx_data_o, 0);
    endtask

    // One start-to-done sequence. stray_t: cycle to re-pulse start (-1 none);
    // rst_field: field whose first REQ cycle gets a reset (-1 none).
    task automatic run_seq(input int stray_t, input int rst_field);
        logic [3:0] exp_slots [16];
        int  stop_f, exp_t, t, f, w, writes;
        bit  exp_to, exp_bcd, ack_prev, fin;
        exp_slots = slots;
        stop_f = NF;
        for (int i = 0; i < NF; i++)
            if (dly[i] >= TO) begin stop_f = i; break; end
        exp_to = (stop_f < NF);
        if (rst_field >= 0 && rst_field < stop_f) stop_f = rst_field;
        exp_t = 1;
        exp_bcd = 1'b0;
        for (int i = 0; i < stop_f; i++) begin
            exp_t += dly[i] + 2;
            exp_slots[i] = filt(dat[i]);
            if (bad_digit(dat[i])) exp_bcd = 1'b1;
        end
        if (exp_to) exp_t += TO;

        start_i = 1'b1;
        t = 0; f = 0; w = 0; writes = 0; ack_prev = 1'b0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk_i);
            t++;
            start_i   = (t == stray_t);
            rd_ack_i  = 1'b0;
            rd_data_i = 4'($urandom);
            if (rst_field >= 0 && rd_req_o && rd_addr_o == 4'(rst_field)) begin
                rst_i = 1'b1;
                #1;
                check_reset_vals("midrst");
                @(negedge clk_i);
                rst_i = 1'b0;
                fin = 1'b1;
            end else begin
                if (t == 1) begin
                    check("t1_busy", busy_o, 1);
                    check("t1_req", rd_req_o, 1);
                    check("t1_tmo_clr", timeout_o, 0);
                    check("t1_bcd_clr", bcd_err_o, 0);
                end
                if (ack_prev) begin
                    check("wr_sel", dmx_sel_o, f);
                    slots[dmx_sel_o] = dmx_data_o;
                    writes++; f++; w = 0;
                end else begin
                    check("park_sel", dmx_sel_o, 15);
                end
                ack_prev = 1'b0;
                if (rd_req_o && f < NF) begin
                    check("rd_addr", rd_addr_o, f);
                    if (w == dly[f]) begin
                        rd_ack_i  = 1'b1;
                        rd_data_i = dat[f];
                        ack_prev  = 1'b1;
                    end else begin
                        w++;
                    end
                end
                if (done_o) begin
                    check("done_latency", t, exp_t);
                    check("done_busy", busy_o, 1);
                    fin = 1'b1;
                end else if (t > exp_t + 40) begin
                    check("done_missing", t, exp_t);
                    fin = 1'b1;
                end
            end
        end
        start_i  = 1'b0;
        rd_ack_i = 1'b0;
        check("writes", writes, stop_f);
        for (int i = 0; i < 16; i++)
            check($sformatf("slot%0d", i), slots[i], exp_slots[i]);
        if (rst_field < 0) begin
            check("timeout", timeout_o, int'(exp_to));
            check("bcd_err", bcd_err_o, int'(exp_bcd));
            @(negedge clk_i);
            check("post_busy", busy_o, 0);
            check("post_done", done_o, 0);
            check("post_sel", dmx_sel_o, 15);
            check("post_tmo_sticky", timeout_o, int'(exp_to));
        end
    endtask

    task automatic set_fields(input int max_dly, input int max_dat);
        for (int i = 0; i < NF; i++) begin
            dly[i] = $urandom_range(0, max_dly);
            dat[i] = 4'($urandom_range(0, max_dat));
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; rd_ack_i = 1'b0; rd_data_i = '0;
        for (int i = 0; i < 16; i++) slots[i] = 4'(i ^ 5);
        repeat (2) @(negedge clk_i);
        check_reset_vals("rst");
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < NF; i++) begin dly[i] = 0; dat[i] = 4'(i + 1); end
        run_seq(-1, -1);

        set_fields(0, 9);
        dly[4] = 3;
        run_seq(-1, -1);

        set_fields(0, 9);
        dly[2] = NEVER;
        run_seq(-1, -1);
        set_fields(0, 9);
        run_seq(-1, -1);

        for (int i = 0; i < 3; i++) begin
            rd_ack_i  = 1'b1;
            rd_data_i = 4'($urandom);
            @(negedge clk_i);
            check("idle_ack_sel", dmx_sel_o, 15);
            check("idle_ack_busy", busy_o, 0);
        end
        rd_ack_i = 1'b0;
        @(negedge clk_i);

        set_fields(0, 9);
        run_seq(-1, 5);
        set_fields(0, 9);
        run_seq(-1, -1);

        set_fields(2, 9);
        run_seq(6, -1);

        set_fields(0, 9);
        dat[3] = 4'hC;
        run_seq(-1, -1);

        for (int r = 0; r < 20; r++) begin
            set_fields(5, 15);
            if ($urandom_range(0, 3) == 0) dly[$urandom_range(0, NF - 1)] = NEVER;
            run_seq(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 18)) : -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
